// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - fetch-side and refill-side signal bundle for the instruction cache
//
// Purpose: groups the IF-stage fetch handshake and the instruction-memory
// block-refill port so the cache and its environment share one connection.
// Signals:
//   address      [31:0]  fetch PC from the IF stage
//   instruction  [31:0]  fetched instruction word
//   busywait             high while instruction is not valid (IF holds PC)
//   mem_read             block read request to instruction memory
//   mem_address  [27:0]  block address {tag,index}
//   mem_readdata [127:0] refill block, word0 in [31:0]
//   mem_busywait         memory busy; data valid when low during mem_read
// Modports: slave = cache side, master = IF stage plus memory side.

interface icache_direct_mapped_if;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with block refill FSM
//
// Purpose: serves 32-bit instruction words to the IF stage from 16-byte lines.
// Hits return in the same cycle; misses refill the indexed line from the
// instruction memory's 128-bit block port, then re-look-up in IDLE.
// Ports:
//   clk   input   rising-edge clock
//   rst   input   asynchronous active-high reset
//   bus   slave   fetch (address/instruction/busywait) and refill
//                 (mem_read/mem_address/mem_readdata/mem_busywait) signals

module icache_direct_mapped #(
  parameter int          INDEX_BITS = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_direct_mapped_if.slave  bus
);

  localparam int          TAG_BITS  = 28 - INDEX_BITS;
  localparam int          NUM_LINES = 1 << INDEX_BITS;
  localparam logic [31:0] SENTINEL  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];
  logic [27:0]          r_mem_address;

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [127:0]          w_line;
  logic [31:0]           w_word;
  logic                  w_hit;
  logic                  w_sentinel;
  logic                  w_latch;
  logic                  w_fill;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic [31:0]           w_instruction;
  logic                  w_busywait;
  logic                  w_mem_read;
  logic                  w_unused;

  assign w_unused   = &{1'b0, bus.address[1:0]};

  assign w_offset   = bus.address[3:2];
  assign w_index    = bus.address[3+INDEX_BITS:4];
  assign w_tag      = bus.address[31:4+INDEX_BITS];
  assign w_sentinel = (bus.address == SENTINEL);

  assign w_line = r_data[w_index];
  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

  always_comb begin
    w_word = w_line[31:0];
    case (w_offset)
      2'd0: w_word = w_line[31:0];
      2'd1: w_word = w_line[63:32];
      2'd2: w_word = w_line[95:64];
      2'd3: w_word = w_line[127:96];
      default: w_word = w_line[31:0];
    endcase
  end

  // The refill targets the block latched on the miss, not the live address,
  // so a PC that wanders during BUSYWAIT cannot corrupt another line.
  assign w_fill_index = r_mem_address[INDEX_BITS-1:0];
  assign w_fill_tag   = r_mem_address[27:INDEX_BITS];

  always_comb begin
    w_next_state  = r_state;
    w_instruction = w_word;
    w_busywait    = 1'b0;
    w_mem_read    = 1'b0;
    w_latch       = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sentinel) begin
          w_instruction = NOP_INSTR;
        end else if (!w_hit) begin
          w_busywait   = 1'b1;
          w_latch      = 1'b1;
          w_next_state = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_busywait = 1'b1;
        if (!bus.mem_busywait) begin
          w_fill       = 1'b1;
          w_next_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_busywait   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Reset overrides combinationally so outputs are quiet for the whole
    // reset pulse, not just from the next edge.
    if (rst) begin
      w_instruction = NOP_INSTR;
      w_busywait    = 1'b0;
      w_mem_read    = 1'b0;
      w_latch       = 1'b0;
      w_fill        = 1'b0;
      w_next_state  = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_mem_address <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_mem_address <= bus.address[31:4];
      end
      if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= bus.mem_readdata;
    end
  end

  assign bus.instruction = w_instruction;
  assign bus.busywait    = w_busywait;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_address = r_mem_address;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed self-checking bench for icache_direct_mapped

module tb_icache_direct_mapped;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mem_lat  = 0;
  int   mem_cnt  = 0;

  icache_direct_mapped_if bus_if ();

  icache_direct_mapped dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [31:0] w0, w1, w2, w3;
    if (b == 28'h0) begin
      return {32'h0000_0033, 32'h0000_0013, 32'h0010_0093, 32'h0000_0297};
    end
    w0 = 32'hA000_0000 | {b, 4'h0} | 32'd0;
    w1 = 32'hA000_0000 | {b, 4'h0} | 32'd1;
    w2 = 32'hA000_0000 | {b, 4'h0} | 32'd2;
    w3 = 32'hA000_0000 | {b, 4'h0} | 32'd3;
    return {w3, w2, w1, w0};
  endfunction

  // Memory model: holds MEM_BUSYWAIT high for mem_lat request cycles, then low with data.
  initial begin
    bus_if.mem_busywait = 1'b1;
    bus_if.mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_read) begin
        if (mem_cnt >= mem_lat) begin
          bus_if.mem_busywait = 1'b0;
          bus_if.mem_readdata = mem_block(bus_if.mem_address);
        end else begin
          bus_if.mem_busywait = 1'b1;
        end
        mem_cnt = mem_cnt + 1;
      end else begin
        mem_cnt = 0;
        bus_if.mem_busywait = 1'b1;
      end
    end
  end

  // Counts BUSYWAIT cycles after the miss cycle; no comparisons here.
  task automatic wait_ready(output int cyc, output logic first_mr, output logic [27:0] first_ma,
                            output logic last_mr, output bit timeout);
    bit done;
    cyc = 0; first_mr = 1'b0; first_ma = '0; last_mr = 1'b0; timeout = 1'b1; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      if (!bus_if.busywait) begin
        done = 1'b1;
        timeout = 1'b0;
      end else begin
        if (cyc == 0) begin
          first_mr = bus_if.mem_read;
          first_ma = bus_if.mem_address;
        end
        last_mr = bus_if.mem_read;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.address = 32'hFFFF_FFFC;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus_if.instruction !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: got %h expected %h", bus_if.instruction, 32'h13); end
    checks++; if (bus_if.busywait !== 1'b0) begin failures++; $display("FAIL reset_busywait: got %b expected 0", bus_if.busywait); end
    checks++; if (bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b expected 0", bus_if.mem_read); end
    checks++; if (bus_if.mem_address !== 28'h0) begin failures++; $display("FAIL reset_mem_address: got %h expected 0", bus_if.mem_address); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus_if.instruction !== 32'h0000_0013) begin failures++; $display("FAIL sentinel_instr: got %h expected %h", bus_if.instruction, 32'h13); end
      checks++; if (bus_if.busywait !== 1'b0) begin failures++; $display("FAIL sentinel_busywait: got %b expected 0", bus_if.busywait); end
      checks++; if (bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL sentinel_mem_read: got %b expected 0", bus_if.mem_read); end
    end
  endtask

  task automatic test_cold_miss();
    int cyc; logic fmr; logic [27:0] fma; logic lmr; bit to;
    @(negedge clk);
    mem_lat = 5;
    bus_if.address = 32'h0000_0000;
    #1;
    checks++; if (bus_if.busywait !== 1'b1) begin failures++; $display("FAIL cold_busywait_now: got %b expected 1", bus_if.busywait); end
    checks++; if (bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL cold_mem_read_idle: got %b expected 0", bus_if.mem_read); end
    wait_ready(cyc, fmr, fma, lmr, to);
    checks++; if (to) begin failures++; $display("FAIL cold_timeout: got timeout expected ready"); end
    checks++; if (cyc != 7) begin failures++; $display("FAIL cold_penalty: got %0d expected 7", cyc); end
    checks++; if (fmr !== 1'b1) begin failures++; $display("FAIL cold_mem_read: got %b expected 1", fmr); end
    checks++; if (fma !== 28'h0) begin failures++; $display("FAIL cold_mem_address: got %h expected 0", fma); end
    checks++; if (lmr !== 1'b0) begin failures++; $display("FAIL cold_update_mem_read: got %b expected 0", lmr); end
    checks++; if (bus_if.instruction !== 32'h0000_0297) begin failures++; $display("FAIL cold_instr: got %h expected %h", bus_if.instruction, 32'h297); end
  endtask

  task automatic test_hits();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 32'h4; exps[0] = 32'h0010_0093;
    addrs[1] = 32'h8; exps[1] = 32'h0000_0013;
    addrs[2] = 32'hC; exps[2] = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.address = addrs[i];
      #1;
      checks++; if (bus_if.instruction !== exps[i]) begin failures++; $display("FAIL hit_instr[%0d]: got %h expected %h", i, bus_if.instruction, exps[i]); end
      checks++; if (bus_if.busywait !== 1'b0) begin failures++; $display("FAIL hit_busywait[%0d]: got %b expected 0", i, bus_if.busywait); end
      checks++; if (bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL hit_mem_read[%0d]: got %b expected 0", i, bus_if.mem_read); end
      @(posedge clk); #1;
      checks++; if (bus_if.busywait !== 1'b0 || bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL hit_stable[%0d]: got bw=%b mr=%b expected 0/0", i, bus_if.busywait, bus_if.mem_read); end
    end
  endtask

  task automatic test_conflict();
    int cyc; logic fmr; logic [27:0] fma; logic lmr; bit to;
    @(negedge clk);
    mem_lat = 2;
    bus_if.address = 32'h0000_0080;
    #1;
    checks++; if (bus_if.busywait !== 1'b1) begin failures++; $display("FAIL conflict_miss: got %b expected 1", bus_if.busywait); end
    wait_ready(cyc, fmr, fma, lmr, to);
    checks++; if (to || cyc != 4) begin failures++; $display("FAIL conflict_penalty: got %0d (timeout=%0d) expected 4", cyc, to); end
    checks++; if (fma !== 28'h000_0008) begin failures++; $display("FAIL conflict_mem_address: got %h expected 0000008", fma); end
    checks++; if (bus_if.instruction !== 32'hA000_0080) begin failures++; $display("FAIL conflict_instr: got %h expected a0000080", bus_if.instruction); end
    @(negedge clk);
    bus_if.address = 32'h0000_0000;
    #1;
    checks++; if (bus_if.busywait !== 1'b1) begin failures++; $display("FAIL evicted_miss: got %b expected 1", bus_if.busywait); end
    wait_ready(cyc, fmr, fma, lmr, to);
    checks++; if (to || cyc != 4) begin failures++; $display("FAIL evicted_penalty: got %0d (timeout=%0d) expected 4", cyc, to); end
    checks++; if (fma !== 28'h0) begin failures++; $display("FAIL evicted_mem_address: got %h expected 0", fma); end
    checks++; if (bus_if.instruction !== 32'h0000_0297) begin failures++; $display("FAIL evicted_instr: got %h expected 00000297", bus_if.instruction); end
  endtask

  task automatic test_reset_mid_refill();
    int cyc; logic fmr; logic [27:0] fma; logic lmr; bit to;
    @(negedge clk);
    mem_lat = 5;
    bus_if.address = 32'h0000_0040;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (bus_if.mem_read !== 1'b1) begin failures++; $display("FAIL midreset_pre_mem_read: got %b expected 1", bus_if.mem_read); end
    rst = 1'b1;
    #1;
    checks++; if (bus_if.mem_read !== 1'b0) begin failures++; $display("FAIL midreset_mem_read: got %b expected 0", bus_if.mem_read); end
    checks++; if (bus_if.busywait !== 1'b0) begin failures++; $display("FAIL midreset_busywait: got %b expected 0", bus_if.busywait); end
    checks++; if (bus_if.instruction !== 32'h0000_0013) begin failures++; $display("FAIL midreset_instr: got %h expected 00000013", bus_if.instruction); end
    checks++; if (bus_if.mem_address !== 28'h0) begin failures++; $display("FAIL midreset_mem_address: got %h expected 0", bus_if.mem_address); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 1;
    bus_if.address = 32'h0000_0000;
    #1;
    checks++; if (bus_if.busywait !== 1'b1) begin failures++; $display("FAIL postreset_miss: got %b expected 1", bus_if.busywait); end
    wait_ready(cyc, fmr, fma, lmr, to);
    checks++; if (to || cyc != 3) begin failures++; $display("FAIL postreset_penalty: got %0d (timeout=%0d) expected 3", cyc, to); end
    checks++; if (bus_if.instruction !== 32'h0000_0297) begin failures++; $display("FAIL postreset_instr: got %h expected 00000297", bus_if.instruction); end
  endtask

  task automatic test_zero_latency();
    int cyc; logic fmr; logic [27:0] fma; logic lmr; bit to;
    @(negedge clk);
    mem_lat = 0;
    bus_if.address = 32'h0000_00A4;
    #1;
    checks++; if (bus_if.busywait !== 1'b1) begin failures++; $display("FAIL zlat_miss: got %b expected 1", bus_if.busywait); end
    wait_ready(cyc, fmr, fma, lmr, to);
    checks++; if (to || cyc != 2) begin failures++; $display("FAIL zlat_penalty: got %0d (timeout=%0d) expected 2", cyc, to); end
    checks++; if (fma !== 28'h000_000A) begin failures++; $display("FAIL zlat_mem_address: got %h expected 000000a", fma); end
    checks++; if (bus_if.instruction !== 32'hA000_00A1) begin failures++; $display("FAIL zlat_instr: got %h expected a00000a1", bus_if.instruction); end
    @(posedge clk); #1;
    checks++; if (bus_if.busywait !== 1'b0 || bus_if.instruction !== 32'hA000_00A1) begin failures++; $display("FAIL zlat_hold: got bw=%b instr=%h expected 0/a00000a1", bus_if.busywait, bus_if.instruction); end
    @(negedge clk);
    bus_if.address = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus_if.instruction !== 32'h0000_0013 || bus_if.busywait !== 1'b0) begin failures++; $display("FAIL sentinel_warm: got instr=%h bw=%b expected 00000013/0", bus_if.instruction, bus_if.busywait); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_reset_mid_refill();
    test_zero_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Instruction cache that sits directly upstream of the IF stage and feeds it INSTRUCTION and BUSYWAIT for the current PC.
- Direct-mapped, read-only, 16-byte (4-word) blocks.
- On a miss it runs a refill FSM against the instruction memory's 128-bit block port, then serves the word.
- The IF stage holds PC while BUSYWAIT is high.

Parameters:
- INDEX_BITS, 3, log2 of block count (default 8 blocks); tag width = 28 - INDEX_BITS.
- NOP_INSTR, 32'h00000013, instruction returned for the reset PC sentinel and while in reset.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDRESS  input  32  fetch address (PC) from IF stage.
- INSTRUCTION  output  32  fetched instruction word.
- BUSYWAIT  output  1  high = INSTRUCTION not valid; IF stage must hold PC.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address {tag,index} to memory.
- MEM_READDATA  input  128  refill block; word0 in [31:0], word3 in [127:96].
- MEM_BUSYWAIT  input  1  memory busy; data valid on the cycle it is low while MEM_READ is high.

Behaviour:
- Address split:
  - [1:0] ignored.
  - [3:2] word offset.
  - [3+INDEX_BITS:4] index.
  - [31:4+INDEX_BITS] tag.
- Storage per line: valid bit, tag, 128-bit data.
- Reset (async):
  - All valid bits cleared; state forced to IDLE.
  - MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=NOP_INSTR while RESET is high.
  - Applies mid-refill: any in-flight request is abandoned, and returned memory data is ignored.
- Sentinel: ADDRESS==32'hFFFF_FFFC (IF reset value) → no lookup, INSTRUCTION=NOP_INSTR, BUSYWAIT=0, no refill.
- Hit (valid & tag match, state IDLE):
  - Combinational, zero-cycle latency: INSTRUCTION = selected word of line, BUSYWAIT=0.
- Miss in IDLE:
  - BUSYWAIT asserted combinationally in the same cycle.
  - Next edge → MEM_READ state.
- FSM states:
  - IDLE: outputs per hit/miss above.
    - Miss → MEM_READ.
    - Otherwise stay.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4] latched at IDLE→MEM_READ transition, BUSYWAIT=1.
    - On an edge with MEM_BUSYWAIT=0: capture MEM_READDATA into data[index], write tag, set valid → UPDATE.
    - With MEM_BUSYWAIT=1: stay.
  - UPDATE: MEM_READ=0, BUSYWAIT=1.
    - Unconditional → IDLE.
    - The line is re-looked-up in IDLE, so hit latency after refill is one further cycle with BUSYWAIT=0.
- Miss penalty: (memory cycles until MEM_BUSYWAIT low) + 2 cycles of BUSYWAIT before the hit cycle.
- ADDRESS must be stable while BUSYWAIT=1. If it does change, the refill still completes to the latched block address. IDLE then re-evaluates the current ADDRESS, which may miss again.
- Refill always overwrites the indexed line (no write-back; cache is read-only).
- INSTRUCTION value is don't-care while BUSYWAIT=1 outside reset.
- No X propagation: INSTRUCTION for an invalid line is driven from stored data, but BUSYWAIT masks it.

Test Plan:
- Reset then ADDRESS=32'hFFFF_FFFC → INSTRUCTION=32'h00000013, BUSYWAIT=0, MEM_READ stays 0.
- Cold miss ADDRESS=0x00000000, memory latency 5 cycles, block=0x...0000_0033_0000_0013_0010_0093_0000_0297:
  - BUSYWAIT=1 immediately, MEM_READ=1 with MEM_ADDRESS=0x0000000.
  - After the MEM_BUSYWAIT fall, UPDATE then IDLE.
  - INSTRUCTION=0x00000297, BUSYWAIT=0.
- Following ADDRESS=0x4, 0x8, 0xC → hits with INSTRUCTION 0x00100093, 0x00000013, 0x00000033, BUSYWAIT never asserted, MEM_READ never asserted.
- Conflict: ADDRESS=0x00000080 (same index 0, tag 1) → miss, refill, MEM_ADDRESS=0x0000008. Then ADDRESS=0x0 → misses again (line evicted).
- Assert RESET in the 2nd cycle of MEM_READ → MEM_READ drops immediately, BUSYWAIT=0. After release, ADDRESS=0x0 misses (valid cleared).
- MEM_BUSYWAIT low on the first MEM_READ cycle (latency 0) → exactly 2 BUSYWAIT cycles, then hit.
